// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 LED panel scanner using binary-coded modulation.
// Scans rows in order and, within each row, bit-planes from MSB to LSB.
// The next plane is shifted in while the previous plane is still lit.
module hub75_bcm_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int BPC      = 4,
    parameter int BASE_ON  = 8,
    localparam int ADDR_W  = ROW_BITS + $clog2(COLS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [2:0]          i_dim,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic                o_ram_read_stb,
    input  logic [3*BPC-1:0]    i_ram_b1_data,
    input  logic [3*BPC-1:0]    i_ram_b2_data,
    output logic                o_data_clock,
    output logic                o_data_latch,
    output logic                o_data_blank,
    output logic [1:0]          o_data_r,
    output logic [1:0]          o_data_g,
    output logic [1:0]          o_data_b,
    output logic [ROW_BITS-1:0] o_row_select,
    output logic                o_frame_start
);

    localparam int COL_W  = $clog2(COLS);
    localparam int PL_W   = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int ON_MAX = BASE_ON << (BPC - 1);
    localparam int ON_W   = $clog2(ON_MAX + 1);

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [PL_W-1:0]  LAST_PLANE = PL_W'(BPC - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREFETCH = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_WAIT_ON  = 3'd3;
    localparam logic [2:0] ST_BLANK    = 3'd4;
    localparam logic [2:0] ST_LATCH    = 3'd5;
    localparam logic [2:0] ST_UNLATCH  = 3'd6;
    localparam logic [2:0] ST_UNBLANK  = 3'd7;

    logic [2:0]          state;
    logic                phase;     // 0: load colour / clock low, 1: clock high
    logic                last_px;   // last pixel of the row has been loaded
    logic [ROW_BITS-1:0] row;
    logic [PL_W-1:0]     plane;
    logic [ON_W-1:0]     on_cnt;

    logic [ROW_BITS-1:0] next_row;
    logic [PL_W-1:0]     next_plane;
    logic                wrap;
    logic [ON_W-1:0]     on_shifted;
    logic [ON_W-1:0]     on_load;

    logic [BPC-1:0] b1_r, b1_g, b1_b;
    logic [BPC-1:0] b2_r, b2_g, b2_b;

    assign b1_r = i_ram_b1_data[3*BPC-1 -: BPC];
    assign b1_g = i_ram_b1_data[2*BPC-1 -: BPC];
    assign b1_b = i_ram_b1_data[BPC-1:0];
    assign b2_r = i_ram_b2_data[3*BPC-1 -: BPC];
    assign b2_g = i_ram_b2_data[2*BPC-1 -: BPC];
    assign b2_b = i_ram_b2_data[BPC-1:0];

    // Next scan position and the on-time for the plane about to be lit.
    always_comb begin
        next_plane = plane - PL_W'(1);
        next_row   = row;
        wrap       = 1'b0;
        if (plane == '0) begin
            next_plane = LAST_PLANE;
            next_row   = row + ROW_BITS'(1);
            wrap       = (row == '1);
        end
        on_shifted = (ON_W'(BASE_ON) << plane) >> i_dim;
        on_load    = (on_shifted == '0) ? ON_W'(1) : on_shifted;
    end

    // Scan sequencer plus on-time counter; the counter is kept in the same
    // block because both it and the sequencer drive o_data_blank.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state          <= ST_IDLE;
            phase          <= 1'b0;
            last_px        <= 1'b0;
            row            <= '0;
            plane          <= LAST_PLANE;
            on_cnt         <= '0;
            o_ram_addr     <= '0;
            o_ram_read_stb <= 1'b0;
            o_data_clock   <= 1'b0;
            o_data_latch   <= 1'b0;
            o_data_blank   <= 1'b1;
            o_data_r       <= '0;
            o_data_g       <= '0;
            o_data_b       <= '0;
            o_row_select   <= '0;
            o_frame_start  <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;

            if (on_cnt != '0) begin
                on_cnt <= on_cnt - ON_W'(1);
                if (on_cnt == ON_W'(1)) begin
                    o_data_blank <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    o_data_clock   <= 1'b0;
                    o_data_latch   <= 1'b0;
                    o_ram_read_stb <= 1'b0;
                    if (on_cnt == '0 && i_enable) begin
                        state          <= ST_PREFETCH;
                        o_ram_addr     <= {row, COL_W'(0)};
                        o_ram_read_stb <= 1'b1;
                        o_frame_start  <= 1'b1;
                    end
                end
                ST_PREFETCH: begin
                    o_ram_read_stb <= 1'b0;
                    phase          <= 1'b0;
                    last_px        <= 1'b0;
                    state          <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Data requested one cycle earlier is on the bus during
                    // the load phase, so the next read is issued here to land
                    // in the following load phase.
                    if (!phase) begin
                        o_data_clock <= 1'b0;
                        o_data_r     <= {b1_r[plane], b2_r[plane]};
                        o_data_g     <= {b1_g[plane], b2_g[plane]};
                        o_data_b     <= {b1_b[plane], b2_b[plane]};
                        if (o_ram_addr[COL_W-1:0] == LAST_COL) begin
                            last_px        <= 1'b1;
                            o_ram_read_stb <= 1'b0;
                        end else begin
                            o_ram_addr     <= o_ram_addr + ADDR_W'(1);
                            o_ram_read_stb <= 1'b1;
                        end
                        phase <= 1'b1;
                    end else begin
                        o_data_clock   <= 1'b1;
                        o_ram_read_stb <= 1'b0;
                        phase          <= 1'b0;
                        if (last_px) begin
                            state <= ST_WAIT_ON;
                        end
                    end
                end
                ST_WAIT_ON: begin
                    o_data_clock <= 1'b0;
                    if (on_cnt == '0) begin
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    o_data_blank <= 1'b1;
                    state        <= ST_LATCH;
                end
                ST_LATCH: begin
                    o_data_latch <= 1'b1;
                    o_row_select <= row;
                    state        <= ST_UNLATCH;
                end
                ST_UNLATCH: begin
                    o_data_latch <= 1'b0;
                    state        <= ST_UNBLANK;
                end
                ST_UNBLANK: begin
                    o_data_blank <= 1'b0;
                    on_cnt       <= on_load;
                    row          <= next_row;
                    plane        <= next_plane;
                    if (wrap && !i_enable) begin
                        state <= ST_IDLE;
                    end else begin
                        state          <= ST_PREFETCH;
                        o_ram_addr     <= {next_row, COL_W'(0)};
                        o_ram_read_stb <= 1'b1;
                        o_frame_start  <= wrap;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
